// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor c = a - b, one magnitude bit per clock, LSB first.
// Saturates on magnitude overflow and never emits negative zero.
module qsub_serial #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_c,
  output logic         o_ovf,
  output logic         o_valid,
  input  logic         i_ready
);

  localparam int M  = N - 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  if (N < 3 || Q > N - 2) begin : g_param_check
    $error("qsub_serial: illegal N/Q combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    NEGATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_q;
  logic [M-1:0]   ma_q, mb_q, res_q;
  logic           cb_q, sa_q, sb_q, sub_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   c_q;
  logic           ovf_q, valid_q, ready_q;

  logic           calc_bit_s, calc_co_s, calc_ovf_s;
  logic           neg_bit_s, neg_co_s;
  logic [M-1:0]   calc_mag_s, calc_res_mag_s, neg_mag_s;
  logic [N-1:0]   calc_c_s, neg_c_s;
  logic [1:0]     add_s, sub_s;

  // {carry_out, sum} of a one-bit full adder
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  // {borrow_out, difference} of a one-bit full subtractor a - b - c
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic c);
    full_sub = {(~a & b) | (c & ~(a ^ b)), a ^ b ^ c};
  endfunction

  // Per-cycle serial arithmetic and the final result words for both exit paths
  always_comb begin
    add_s          = full_add(ma_q[0], mb_q[0], cb_q);
    sub_s          = full_sub(ma_q[0], mb_q[0], cb_q);
    calc_bit_s     = sub_q ? sub_s[0] : add_s[0];
    calc_co_s      = sub_q ? sub_s[1] : add_s[1];
    calc_mag_s     = {calc_bit_s, res_q[M-1:1]};
    calc_ovf_s     = ~sub_q & calc_co_s;
    calc_res_mag_s = calc_ovf_s ? {M{1'b1}} : calc_mag_s;
    calc_c_s       = {sa_q & (|calc_res_mag_s), calc_res_mag_s};
    // Two's-complement negate: invert and add the carry seeded with 1
    neg_bit_s      = ~res_q[0] ^ cb_q;
    neg_co_s       = ~res_q[0] & cb_q;
    neg_mag_s      = {neg_bit_s, res_q[M-1:1]};
    neg_c_s        = {sb_q & (|neg_mag_s), neg_mag_s};
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      res_q   <= '0;
      cb_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            ma_q    <= i_a[N-2:0];
            mb_q    <= i_b[N-2:0];
            sa_q    <= i_a[N-1];
            sb_q    <= ~i_b[N-1];
            sub_q   <= i_a[N-1] ^ ~i_b[N-1];
            res_q   <= '0;
            cb_q    <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          ma_q  <= ma_q >> 1;
          mb_q  <= mb_q >> 1;
          res_q <= calc_mag_s;
          cb_q  <= calc_co_s;
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (sub_q && calc_co_s) begin
              cb_q    <= 1'b1;
              state_q <= NEGATE;
            end else begin
              c_q     <= calc_c_s;
              ovf_q   <= calc_ovf_s;
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        NEGATE: begin
          res_q <= neg_mag_s;
          cb_q  <= neg_co_s;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            c_q     <= neg_c_s;
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_c     = c_q;
  assign o_ovf   = ovf_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_qsub_serial.sv
// Directed scoreboard bench for qsub_serial (N=32, Q=15).
module tb_qsub_serial;

  localparam int N = 32;
  localparam int Q = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_a, i_b, o_c;
  logic         i_valid, i_ready, o_ready, o_ovf, o_valid;

  typedef struct {
    logic [N-1:0] c;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  qsub_serial #(.Q(Q), .N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_c     (o_c),
    .o_ovf   (o_ovf),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic rdy,
                      input logic [N-1:0] ec, input logic eovf, input int lat);
    exp_t e;
    @(negedge clk);
    check("ready_before_accept", {63'd0, o_ready}, 64'd1);
    i_a     = a;
    i_b     = b;
    i_valid = 1'b1;
    i_ready = rdy;
    e.c = ec; e.ovf = eovf; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_a     = ~a;
    i_b     = ~b;
    check("ready_low_after_accept", {63'd0, o_ready}, 64'd0);
  endtask

  task automatic wait_result();
    int   cyc = 0;
    exp_t e;
    while (o_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) begin
      check("valid_timeout", {63'd0, o_valid}, 64'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_valid", {63'd0, o_valid}, 64'd0);
    end else begin
      e = sb.pop_front();
      check("latency", 64'(cyc), 64'(e.lat));
      check("o_c", {32'd0, o_c}, {32'd0, e.c});
      check("o_ovf", {63'd0, o_ovf}, {63'd0, e.ovf});
      check("ready_low_in_done", {63'd0, o_ready}, 64'd0);
    end
  endtask

  task automatic handshake_zero_wait(input logic [N-1:0] ec);
    @(posedge clk);
    #1;
    check("valid_one_cycle", {63'd0, o_valid}, 64'd0);
    check("ready_after_take", {63'd0, o_ready}, 64'd1);
    check("o_c_held", {32'd0, o_c}, {32'd0, ec});
  endtask

  initial begin
    rst_n   = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    #12;
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_c", {32'd0, o_c}, 64'd0);
    check("rst_ovf", {63'd0, o_ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 10.0 - 5.0
    send(32'h0005_0000, 32'h0002_8000, 1'b1, 32'h0002_8000, 1'b0, 31);
    wait_result();
    handshake_zero_wait(32'h0002_8000);
    // 5.0 - 10.0 through NEGATE
    send(32'h0002_8000, 32'h0005_0000, 1'b1, 32'h8002_8000, 1'b0, 62);
    wait_result();
    handshake_zero_wait(32'h8002_8000);
    // (-3.0) - (-3.0): no negative zero
    send(32'h8001_8000, 32'h8001_8000, 1'b1, 32'h0000_0000, 1'b0, 31);
    wait_result();
    handshake_zero_wait(32'h0000_0000);
    // Saturating overflow
    send(32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 31);
    wait_result();
    handshake_zero_wait(32'h7FFF_FFFF);
    // 3 - 4 in raw units through NEGATE
    send(32'h0000_0003, 32'h0000_0004, 1'b1, 32'h8000_0001, 1'b0, 62);
    wait_result();
    handshake_zero_wait(32'h8000_0001);

    // Backpressure: result held, new operands ignored
    send(32'h0005_0000, 32'h0002_8000, 1'b0, 32'h0002_8000, 1'b0, 31);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_a     = 32'h1111_1111 + 32'(i);
      i_b     = 32'h8222_2222;
      @(posedge clk);
      #1;
      check("bp_valid", {63'd0, o_valid}, 64'd1);
      check("bp_c", {32'd0, o_c}, 64'h0002_8000);
      check("bp_ready", {63'd0, o_ready}, 64'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {63'd0, o_valid}, 64'd0);
    check("bp_release_ready", {63'd0, o_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_not_captured", {63'd0, o_ready}, 64'd1);
    end

    // Reset mid-CALC aborts the operation
    send(32'h0005_0000, 32'h0002_8000, 1'b1, 32'h0002_8000, 1'b0, 31);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {63'd0, o_ready}, 64'd1);
    check("abort_valid", {63'd0, o_valid}, 64'd0);
    check("abort_c", {32'd0, o_c}, 64'd0);
    check("abort_ovf", {63'd0, o_ovf}, 64'd0);
    sb.delete(sb.size() - 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", {63'd0, o_valid}, 64'd0);
    end
    // 1.0 - 0.5 after the abort
    send(32'h0000_8000, 32'h0000_4000, 1'b1, 32'h0000_4000, 1'b0, 31);
    wait_result();
    handshake_zero_wait(32'h0000_4000);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
